div_arb_ctrl: RTL and testbench
===============================

# div_arb_ctrl

Sequencing controller and round-robin arbiter that shares one iterative divider datapath among NREQ requesters. It accepts a dividend/divisor pair from one requester at a time and loads it into the divider by pulsing the divider's synchronous load/reset. It waits for the divider's done flag, then returns quotient and remainder to the owning requester over a valid/ready response channel. It sits between the requester-side logic and the divider, and is the divider's only driver.

## Interface
- SIZE, 16, operand/result width; matches divider SIZE
- NREQ, 4, number of requesters, 2..8
- IDW, 2, requester index width, ceil(log2(NREQ))
- TIMEOUT, 64, watchdog limit in cycles (used only with macro below)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept pulse
- req_a  in  NREQ*SIZE  dividends; requester i at bits [i*SIZE +: SIZE]
- req_b  in  NREQ*SIZE  divisors, same packing
- rsp_valid  out  NREQ  one-hot response valid, to the owner only
- rsp_ready  in  NREQ  per-requester response accept
- rsp_q  out  SIZE  quotient
- rsp_rem  out  SIZE  remainder
- rsp_err  out  1  1 = divide-by-zero (or timeout)
- rsp_id  out  IDW  owner index
- dv_load  out  1  to divider reset; 1-cycle pulse loads dv_a/dv_b
- dv_a, dv_b  out  SIZE  operands to divider, held stable from LOAD to the end of WAIT
- dv_done  in  1  divider done
- dv_q, dv_rem  in  SIZE  divider results
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
  - req_ready[grant] is combinationally 1 in the same cycle. The handshake is req_valid&req_ready.
  - On handshake: latch A/B and owner.
  - If B != 0: go to LOAD.
  - If B == 0: go to RESP with Q = all ones, Rem = A, err = 1. The divider is not touched.
- LOAD: dv_load=1 for exactly one cycle, then WAIT.
- WAIT:
  - dv_done is ignored in the first WAIT cycle because the divider is still clearing done.
  - On dv_done=1: capture dv_q/dv_rem, err=0, go to RESP.
- RESP:
  - rsp_valid[owner]=1. rsp_q, rsp_rem, rsp_err and rsp_id are held stable until rsp_ready[owner]=1.
  - On that handshake: rr_ptr = owner+1 (wraps NREQ-1 -> 0), then IDLE.
  - rsp_ready of non-owners is ignored.
- One transaction is in flight at a time. req_ready is 0 in every state except IDLE.
- A requester may withdraw req_valid before it is accepted. No request is lost or duplicated.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_q=0, rsp_rem=0, rsp_err=0, rsp_id=0, dv_load=0, dv_a=0, dv_b=0, busy=0.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight result is discarded and no response is issued. dv_load stays 0 until the next accept.
- Latency, accept at cycle T:
  - dv_load=1 in T+1.
  - WAIT begins in T+2.
  - dv_done first sampled at T+3; if seen at cycle D, rsp_valid rises at D+1.
- Zero divisor: rsp_valid rises at T+1.
- Minimum request-to-request spacing: response handshake at R, next req_ready possible at R+1.
- Several requesters valid at once: exactly one req_ready bit is set, always the first at or after rr_ptr.

## Configuration
- DIV_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If dv_done is not seen within TIMEOUT cycles of entering WAIT, go to RESP with err=1, Q=0, Rem=latched A.
  - The counter clears on every WAIT entry and on reset.
- DIV_ARB_TIMEOUT_EN not defined: no counter logic; WAIT exits only on dv_done.

## Test plan
- Single request, requester 2, A=100, B=7; divider model asserts done 16 cycles after load -> req_ready[2] at T, dv_load at T+1, rsp_valid[2] with q=14, rem=2, err=0, id=2.
- Requesters 0, 1 and 3 all valid continuously, rr_ptr=0 -> grants in order 0, 1, 3, 0; no requester is granted twice before the others are served.
- Requester 1, A=55, B=0 -> rsp_valid[1] at T+1 with q=16'hFFFF, rem=55, err=1; dv_load never asserts.
- rsp_ready held 0 for 10 cycles in RESP -> outputs stable and req_ready all 0 throughout; on rsp_ready=1, next grant possible the following cycle.
- reset driven low during WAIT, then a late dv_done -> no rsp_valid; after release, state=IDLE and rr_ptr=0.
- With DIV_ARB_TIMEOUT_EN, TIMEOUT=64, dv_done held 0 -> rsp_valid exactly 65 cycles after WAIT entry with err=1, q=0.

Source files
------------

// File: rtl/div_arb_ctrl.sv
// Round-robin arbiter and sequencer that shares one iterative divider among NREQ requesters.
// Optional watchdog on the divider done flag is enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arb_ctrl #(
    parameter int SIZE    = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [SIZE-1:0]      rsp_q,
    output logic [SIZE-1:0]      rsp_rem,
    output logic                 rsp_err,
    output logic [IDW-1:0]       rsp_id,
    output logic                 dv_load,
    output logic [SIZE-1:0]      dv_a,
    output logic [SIZE-1:0]      dv_b,
    input  logic                 dv_done,
    input  logic [SIZE-1:0]      dv_q,
    input  logic [SIZE-1:0]      dv_rem,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] res_q_q, res_q_d;
    logic [SIZE-1:0] res_rem_q, res_rem_d;
    logic            err_q, err_d;
    logic            first_wait_q, first_wait_d;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [SIZE-1:0] grant_a;
    logic [SIZE-1:0] grant_b;
    int              scan_idx;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    assign grant_a = req_a[int'(grant_idx)*SIZE +: SIZE];
    assign grant_b = req_b[int'(grant_idx)*SIZE +: SIZE];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        res_q_d      = res_q_q;
        res_rem_d    = res_rem_q;
        err_d        = err_q;
        first_wait_d = 1'b0;
        req_ready    = '0;
        rsp_valid    = '0;
        dv_load      = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready = NREQ'(1) << grant_idx;
                    owner_d   = grant_idx;
                    // A zero divisor is answered directly and never reaches the divider.
                    if (grant_b != '0) begin
                        a_d     = grant_a;
                        b_d     = grant_b;
                        state_d = S_LOAD;
                    end else begin
                        res_q_d   = '1;
                        res_rem_d = grant_a;
                        err_d     = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_LOAD: begin
                dv_load      = 1'b1;
                first_wait_d = 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
                tmo_cnt_d    = '0;
`endif
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // Done is stale in the first WAIT cycle while the divider clears it.
                if (!first_wait_q && dv_done) begin
                    res_q_d   = dv_q;
                    res_rem_d = dv_rem;
                    err_d     = 1'b0;
                    state_d   = S_RESP;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT)) begin
                    res_q_d   = '0;
                    res_rem_d = a_q;
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << owner_q;
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q_q      <= '0;
            res_rem_q    <= '0;
            err_q        <= 1'b0;
            first_wait_q <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q_q      <= res_q_d;
            res_rem_q    <= res_rem_d;
            err_q        <= err_d;
            first_wait_q <= first_wait_d;
`ifdef DIV_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign rsp_q   = res_q_q;
    assign rsp_rem = res_rem_q;
    assign rsp_err = err_q;
    assign rsp_id  = owner_q;
    assign dv_a    = a_q;
    assign dv_b    = b_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_arb_ctrl.sv
// Directed bench for div_arb_ctrl with a behavioural divider that raises done a fixed delay after load.
// The watchdog scenario is only exercised when DIV_ARB_TIMEOUT_EN is defined.
module tb_div_arb_ctrl;

    localparam int SIZE     = 16;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int TIMEOUT  = 64;
    localparam int DONE_LAT = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [SIZE-1:0]      rsp_q;
    logic [SIZE-1:0]      rsp_rem;
    logic                 rsp_err;
    logic [IDW-1:0]       rsp_id;
    logic                 dv_load;
    logic [SIZE-1:0]      dv_a;
    logic [SIZE-1:0]      dv_b;
    logic                 dv_done;
    logic [SIZE-1:0]      dv_q;
    logic [SIZE-1:0]      dv_rem;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;
    int load_cnt    = 0;

    logic            model_en   = 1'b1;
    logic            force_done = 1'b0;
    logic            mdl_done   = 1'b0;
    int              mdl_cnt    = 0;
    logic [SIZE-1:0] mdl_q      = '0;
    logic [SIZE-1:0] mdl_rem    = '0;

    div_arb_ctrl #(
        .SIZE(SIZE), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_rem(rsp_rem), .rsp_err(rsp_err), .rsp_id(rsp_id),
        .dv_load(dv_load), .dv_a(dv_a), .dv_b(dv_b),
        .dv_done(dv_done), .dv_q(dv_q), .dv_rem(dv_rem),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Divider model: done rises DONE_LAT cycles after the load pulse and holds until the next load.
    always @(posedge clk) begin
        if (dv_load) begin
            mdl_cnt  <= DONE_LAT;
            mdl_done <= 1'b0;
            mdl_q    <= dv_a / dv_b;
            mdl_rem  <= dv_a % dv_b;
        end else if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (mdl_cnt == 1) begin
            mdl_done <= 1'b1;
            mdl_cnt  <= 0;
        end
    end

    always @(posedge clk) begin
        if (dv_load) load_cnt <= load_cnt + 1;
    end

    assign dv_done = (model_en & mdl_done) | force_done;
    assign dv_q    = mdl_q;
    assign dv_rem  = mdl_rem;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int limit, output int cycles);
        cycles = 0;
        while (rsp_valid == '0 && cycles < limit) begin
            next_cycle();
            cycles++;
        end
    endtask

    initial begin : stimulus
        int             cyc;
        int             loads_before;
        logic [IDW-1:0] gnt_tab [4];
        logic [SIZE-1:0] q_tab  [4];
        logic [SIZE-1:0] r_tab  [4];

        gnt_tab = '{2'd0, 2'd1, 2'd3, 2'd0};
        q_tab   = '{16'd6, 16'd7, 16'd0, 16'd8};
        r_tab   = '{16'd2, 16'd2, 16'd0, 16'd5};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        next_cycle();
        next_cycle();
        check_output("rst_req_ready", 32'(req_ready), 32'h0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("rst_rsp_q",     32'(rsp_q),     32'h0);
        check_output("rst_rsp_rem",   32'(rsp_rem),   32'h0);
        check_output("rst_rsp_err",   32'(rsp_err),   32'h0);
        check_output("rst_rsp_id",    32'(rsp_id),    32'h0);
        check_output("rst_dv_load",   32'(dv_load),   32'h0);
        check_output("rst_dv_a",      32'(dv_a),      32'h0);
        check_output("rst_dv_b",      32'(dv_b),      32'h0);
        check_output("rst_busy",      32'(busy),      32'h0);
        rst_n = 1'b1;

        // Single request from requester 2: 100 / 7.
        next_cycle();
        req_a[2*SIZE +: SIZE] = 16'd100;
        req_b[2*SIZE +: SIZE] = 16'd7;
        req_valid = 4'b0100;
        #1;
        check_output("t1_req_ready", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = '0;
        check_output("t1_load_pulse", 32'(dv_load), 32'h1);
        check_output("t1_dv_a",       32'(dv_a),    32'd100);
        check_output("t1_dv_b",       32'(dv_b),    32'd7);
        next_cycle();
        check_output("t1_load_single", 32'(dv_load), 32'h0);
        check_output("t1_busy",        32'(busy),    32'h1);
        wait_rsp(40, cyc);
        check_output("t1_rsp_latency", 32'(cyc),       32'd17);
        check_output("t1_rsp_valid",   32'(rsp_valid), 32'h4);
        check_output("t1_rsp_q",       32'(rsp_q),     32'd14);
        check_output("t1_rsp_rem",     32'(rsp_rem),   32'd2);
        check_output("t1_rsp_err",     32'(rsp_err),   32'h0);
        check_output("t1_rsp_id",      32'(rsp_id),    32'd2);
        rsp_ready = 4'b0100;
        next_cycle();
        rsp_ready = '0;
        check_output("t1_rsp_done", 32'(rsp_valid), 32'h0);
        check_output("t1_idle",     32'(busy),      32'h0);

        // Round robin from rr_ptr=0 with requesters 0, 1, 3 continuously valid.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        req_a[0*SIZE +: SIZE] = 16'd20; req_b[0*SIZE +: SIZE] = 16'd3;
        req_a[1*SIZE +: SIZE] = 16'd30; req_b[1*SIZE +: SIZE] = 16'd4;
        req_a[3*SIZE +: SIZE] = 16'd53; req_b[3*SIZE +: SIZE] = 16'd6;
        req_valid = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            #1;
            check_output($sformatf("rr%0d_grant", n), 32'(req_ready), 32'(4'b0001 << gnt_tab[n]));
            wait_rsp(40, cyc);
            check_output($sformatf("rr%0d_latency", n), 32'(cyc),       32'd19);
            check_output($sformatf("rr%0d_valid", n),   32'(rsp_valid), 32'(4'b0001 << gnt_tab[n]));
            check_output($sformatf("rr%0d_id", n),      32'(rsp_id),    32'(gnt_tab[n]));
            check_output($sformatf("rr%0d_q", n),       32'(rsp_q),     32'(q_tab[gnt_tab[n]]));
            check_output($sformatf("rr%0d_rem", n),     32'(rsp_rem),   32'(r_tab[gnt_tab[n]]));
            rsp_ready = 4'b0001 << gnt_tab[n];
            next_cycle();
            rsp_ready = '0;
        end
        req_valid = '0;

        // Zero divisor from requester 1, then a stalled response.
        next_cycle();
        loads_before = load_cnt;
        req_a[1*SIZE +: SIZE] = 16'd55;
        req_b[1*SIZE +: SIZE] = 16'd0;
        req_valid = 4'b0010;
        #1;
        check_output("dz_grant", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'b1111;
        #1;
        check_output("dz_rsp_valid", 32'(rsp_valid), 32'h2);
        check_output("dz_rsp_q",     32'(rsp_q),     32'hFFFF);
        check_output("dz_rsp_rem",   32'(rsp_rem),   32'd55);
        check_output("dz_rsp_err",   32'(rsp_err),   32'h1);
        check_output("dz_rsp_id",    32'(rsp_id),    32'd1);
        check_output("dz_no_load",   32'(dv_load),   32'h0);
        for (int s = 0; s < 10; s++) begin
            next_cycle();
            check_output($sformatf("stall%0d_valid", s), 32'(rsp_valid), 32'h2);
            check_output($sformatf("stall%0d_q", s),     32'(rsp_q),     32'hFFFF);
            check_output($sformatf("stall%0d_rem", s),   32'(rsp_rem),   32'd55);
            check_output($sformatf("stall%0d_ready", s), 32'(req_ready), 32'h0);
        end
        rsp_ready = 4'b1101;
        next_cycle();
        check_output("nonowner_ignored", 32'(rsp_valid), 32'h2);
        rsp_ready = 4'b0010;
        next_cycle();
        rsp_ready = '0;
        check_output("next_grant_r1", 32'(req_ready), 32'h4);
        req_valid = '0;
        next_cycle();
        check_output("withdraw_idle",  32'(busy),                    32'h0);
        check_output("dz_load_count",  32'(load_cnt - loads_before), 32'h0);

        // Reset during WAIT, then a late done must not produce a response.
        model_en = 1'b0;
        req_a[0*SIZE +: SIZE] = 16'd1000;
        req_b[0*SIZE +: SIZE] = 16'd3;
        req_valid = 4'b0001;
        #1;
        check_output("rw_grant", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = '0;
        check_output("rw_load", 32'(dv_load), 32'h1);
        next_cycle();
        next_cycle();
        check_output("rw_wait_busy", 32'(busy), 32'h1);
        check_output("rw_dv_a_hold", 32'(dv_a), 32'd1000);
        rst_n = 1'b0;
        #1;
        check_output("rw_rst_busy",  32'(busy),      32'h0);
        check_output("rw_rst_valid", 32'(rsp_valid), 32'h0);
        check_output("rw_rst_dv_a",  32'(dv_a),      32'h0);
        next_cycle();
        rst_n = 1'b1;
        force_done = 1'b1;
        for (int s = 0; s < 3; s++) begin
            next_cycle();
            check_output($sformatf("late%0d_valid", s), 32'(rsp_valid), 32'h0);
            check_output($sformatf("late%0d_busy", s),  32'(busy),      32'h0);
            check_output($sformatf("late%0d_load", s),  32'(dv_load),   32'h0);
        end
        force_done = 1'b0;
        req_valid = 4'b1111;
        #1;
        check_output("rw_rr_ptr_zero", 32'(req_ready), 32'h1);
        req_valid = '0;
        next_cycle();

`ifdef DIV_ARB_TIMEOUT_EN
        // Watchdog: done never arrives, response lands 65 cycles after WAIT entry.
        req_a[3*SIZE +: SIZE] = 16'd77;
        req_b[3*SIZE +: SIZE] = 16'd5;
        req_valid = 4'b1000;
        #1;
        check_output("to_grant", 32'(req_ready), 32'h8);
        next_cycle();
        req_valid = '0;
        wait_rsp(100, cyc);
        check_output("to_latency", 32'(cyc),       32'd66);
        check_output("to_valid",   32'(rsp_valid), 32'h8);
        check_output("to_err",     32'(rsp_err),   32'h1);
        check_output("to_q",       32'(rsp_q),     32'h0);
        check_output("to_rem",     32'(rsp_rem),   32'd77);
        rsp_ready = 4'b1000;
        next_cycle();
        rsp_ready = '0;
        check_output("to_idle", 32'(busy), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
